// File: rtl/parking_gate_arbiter.sv
// Arbitrates gate entry/exit requests onto a single allocation-core command port,
// then acknowledges the winning gate and holds its door open for a fixed time.
module parking_gate_arbiter #(
  parameter int N_GATES     = 4,
  parameter int SLOT_W      = 2,
  parameter int DOOR_CYCLES = 8,
  parameter int TIMEOUT     = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_GATES-1:0]          req,
  input  logic [N_GATES-1:0]          req_exit,
  input  logic [N_GATES*SLOT_W-1:0]   req_slot,
  output logic                        cmd_valid,
  output logic                        cmd_exit,
  output logic [SLOT_W-1:0]           cmd_slot,
  input  logic                        cmd_done,
  input  logic                        cmd_ok,
  input  logic [SLOT_W-1:0]           cmd_slot_rsp,
  output logic [N_GATES-1:0]          ack,
  output logic                        ack_ok,
  output logic [SLOT_W-1:0]           ack_slot,
  output logic [N_GATES-1:0]          door_open,
  output logic                        busy
);

  localparam int IDX_W   = $clog2(N_GATES);
  localparam int CNT_MAX = (TIMEOUT > DOOR_CYCLES) ? TIMEOUT : DOOR_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, ACK, DOOR} state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    rr_ptr, gnt_idx, pick_idx;
  logic                pick_found;
  logic [N_GATES-1:0]  cand;
  logic [SLOT_W-1:0]   pick_slot;
  logic [CNT_W-1:0]    cnt;
  logic                exit_q, ok_q;
  logic [SLOT_W-1:0]   slot_q, rsp_q;
  logic [N_GATES-1:0]  gate_oh;
  logic                timeout_hit, door_last;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign door_last   = (cnt == CNT_W'(DOOR_CYCLES - 2));

  // Exit requesters mask out entries; then a two-pass scan gives round-robin
  // order starting at rr_ptr without any modulo arithmetic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cand       = (|(req & req_exit)) ? (req & req_exit) : req;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_slot  = '0;
    for (int g = 0; g < N_GATES; g++) begin
      if (!pick_found && cand[g] && (IDX_W'(g) >= rr_ptr)) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(g);
      end
    end
    for (int g = 0; g < N_GATES; g++) begin
      if (!pick_found && cand[g]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(g);
      end
    end
    for (int g = 0; g < N_GATES; g++) begin
      if (IDX_W'(g) == pick_idx) pick_slot = req_slot[g*SLOT_W +: SLOT_W];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = ISSUE;
      ISSUE:   if (cmd_done || timeout_hit) state_nx = ACK;
      ACK:     state_nx = (ok_q && DOOR_CYCLES > 1) ? DOOR : IDLE;
      DOOR:    if (door_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together on the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr  <= '0;
      gnt_idx <= '0;
      exit_q  <= 1'b0;
      slot_q  <= '0;
      ok_q    <= 1'b0;
      rsp_q   <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (|req) begin
            gnt_idx <= pick_idx;
            exit_q  <= req_exit[pick_idx];
            slot_q  <= req_exit[pick_idx] ? pick_slot : '0;
            rr_ptr  <= (pick_idx == IDX_W'(N_GATES - 1)) ? '0 : pick_idx + 1'b1;
          end
        end
        ISSUE: begin
          // A response in the timeout cycle still counts as a real answer.
          if (cmd_done) begin
            ok_q  <= cmd_ok;
            rsp_q <= cmd_ok ? cmd_slot_rsp : '0;
          end else if (timeout_hit) begin
            ok_q  <= 1'b0;
            rsp_q <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ACK:     cnt <= '0;
        DOOR:    cnt <= cnt + 1'b1;
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs decode only registered state, so no input reaches an output combinationally.
  assign gate_oh   = N_GATES'(1) << gnt_idx;
  assign cmd_valid = (state == ISSUE);
  assign cmd_exit  = exit_q;
  assign cmd_slot  = slot_q;
  assign busy      = (state != IDLE);
  assign ack       = (state == ACK) ? gate_oh : '0;
  assign ack_ok    = (state == ACK) && ok_q;
  assign ack_slot  = (state == ACK) ? rsp_q : '0;
  assign door_open = (((state == ACK) && ok_q) || (state == DOOR)) ? gate_oh : '0;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter: a vector table for grant selection
// plus hand-written sequences for timing, timeout, reset and round robin.
module tb_parking_gate_arbiter;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int DC = 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req, req_exit;
  logic [N*SW-1:0] req_slot;
  logic            cmd_valid, cmd_exit;
  logic [SW-1:0]   cmd_slot;
  logic            cmd_done, cmd_ok;
  logic [SW-1:0]   cmd_slot_rsp;
  logic [N-1:0]    ack;
  logic            ack_ok;
  logic [SW-1:0]   ack_slot;
  logic [N-1:0]    door_open;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  parking_gate_arbiter #(.N_GATES(N), .SLOT_W(SW), .DOOR_CYCLES(DC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_exit(req_exit), .req_slot(req_slot),
    .cmd_valid(cmd_valid), .cmd_exit(cmd_exit), .cmd_slot(cmd_slot),
    .cmd_done(cmd_done), .cmd_ok(cmd_ok), .cmd_slot_rsp(cmd_slot_rsp),
    .ack(ack), .ack_ok(ack_ok), .ack_slot(ack_slot), .door_open(door_open), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    req;
    logic [N-1:0]    req_exit;
    logic [N*SW-1:0] req_slot;
    logic            ok;
    logic [SW-1:0]   rsp;
    logic [N-1:0]    gate;
    logic            exp_exit;
    logic [SW-1:0]   exp_slot;
    logic [SW-1:0]   exp_ack_slot;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to the negative edge of the next cycle.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string name);
    check({name, " cmd_valid"}, 32'(cmd_valid), 0);
    check({name, " ack"},       32'(ack),       0);
    check({name, " door_open"}, 32'(door_open), 0);
    check({name, " busy"},      32'(busy),      0);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; req_exit = '0; req_slot = '0;
    cmd_done = 1'b0; cmd_ok = 1'b0; cmd_slot_rsp = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!cmd_valid && n < 40) begin
      tick();
      n++;
    end
    if (!cmd_valid) check({name, " wait cmd_valid expired"}, 32'(cmd_valid), 1);
  endtask

  int vc, dcnt, nw;
  logic [N-1:0] rr_exp[5];

  initial begin
    vecs[0] = '{4'b0001, 4'b0000, 8'h00,        1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 2'd0};
    vecs[1] = '{4'b0011, 4'b0010, 8'b0000_1100, 1'b1, 2'd3, 4'b0010, 1'b1, 2'd3, 2'd3};
    vecs[2] = '{4'b1111, 4'b0000, 8'h00,        1'b0, 2'd0, 4'b0100, 1'b0, 2'd0, 2'd0};
    vecs[3] = '{4'b1111, 4'b0000, 8'h00,        1'b0, 2'd1, 4'b1000, 1'b0, 2'd0, 2'd0};
    vecs[4] = '{4'b1111, 4'b0000, 8'h00,        1'b1, 2'd1, 4'b0001, 1'b0, 2'd0, 2'd1};
    vecs[5] = '{4'b0101, 4'b0001, 8'b0000_0010, 1'b0, 2'd0, 4'b0001, 1'b1, 2'd2, 2'd0};
    vecs[6] = '{4'b1001, 4'b1001, 8'b0100_0010, 1'b0, 2'd0, 4'b1000, 1'b1, 2'd1, 2'd0};
    vecs[7] = '{4'b0100, 4'b0000, 8'hFF,        1'b1, 2'd2, 4'b0100, 1'b0, 2'd0, 2'd2};
    vecs[8] = '{4'b0011, 4'b0000, 8'h00,        1'b0, 2'd3, 4'b0001, 1'b0, 2'd0, 2'd0};
    vecs[9] = '{4'b1110, 4'b0110, 8'b0010_0100, 1'b0, 2'd0, 4'b0010, 1'b1, 2'd1, 2'd0};
    rr_exp  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    @(negedge clk);
    do_reset();
    check_quiet("reset");
    check("reset cmd_exit", 32'(cmd_exit), 0);
    check("reset cmd_slot", 32'(cmd_slot), 0);
    check("reset ack_ok",   32'(ack_ok),   0);
    check("reset ack_slot", 32'(ack_slot), 0);

    // Table: each vector is a minimum-latency transaction (cmd_done at t+1).
    foreach (vecs[i]) begin
      req = vecs[i].req; req_exit = vecs[i].req_exit; req_slot = vecs[i].req_slot;
      tick();
      check($sformatf("v%0d cmd_valid", i), 32'(cmd_valid), 1);
      check($sformatf("v%0d cmd_exit", i),  32'(cmd_exit),  32'(vecs[i].exp_exit));
      check($sformatf("v%0d cmd_slot", i),  32'(cmd_slot),  32'(vecs[i].exp_slot));
      cmd_done = 1'b1; cmd_ok = vecs[i].ok; cmd_slot_rsp = vecs[i].rsp;
      tick();
      cmd_done = 1'b0; cmd_ok = 1'b0; cmd_slot_rsp = '0; req = '0;
      check($sformatf("v%0d ack", i),       32'(ack),       32'(vecs[i].gate));
      check($sformatf("v%0d ack_ok", i),    32'(ack_ok),    32'(vecs[i].ok));
      check($sformatf("v%0d ack_slot", i),  32'(ack_slot),  32'(vecs[i].exp_ack_slot));
      check($sformatf("v%0d door", i),      32'(door_open), vecs[i].ok ? 32'(vecs[i].gate) : 0);
      if (vecs[i].ok) begin
        repeat (DC - 1) tick();
        check($sformatf("v%0d door last", i), 32'(door_open), 32'(vecs[i].gate));
      end
      tick();
      check_quiet($sformatf("v%0d idle", i));
    end

    // Single entry, cmd_done at t+3; gate drops req right after grant.
    do_reset();
    req = 4'b0001;
    tick();
    req = '0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("single cmd_valid t+%0d", c), 32'(cmd_valid), 1);
      if (c < 3) tick();
    end
    cmd_done = 1'b1; cmd_ok = 1'b1; cmd_slot_rsp = 2'd2;
    tick();
    cmd_done = 1'b0; cmd_ok = 1'b0; cmd_slot_rsp = '0;
    check("single ack",       32'(ack),       32'b0001);
    check("single ack_slot",  32'(ack_slot),  2);
    check("single cmd_valid", 32'(cmd_valid), 0);
    dcnt = 0;
    for (int c = 0; c < DC; c++) begin
      if (door_open == 4'b0001) dcnt++;
      tick();
    end
    check("single door cycles", 32'(dcnt), DC);
    check_quiet("single t+12");

    // Timeout with a late cmd_done that must be ignored.
    do_reset();
    req = 4'b0010;
    tick();
    req = '0;
    vc = 0;
    for (int c = 0; c < TO; c++) begin
      if (cmd_valid) vc++;
      tick();
    end
    check("timeout cmd_valid cycles", 32'(vc),       TO);
    check("timeout ack",              32'(ack),      32'b0010);
    check("timeout ack_ok",           32'(ack_ok),   0);
    check("timeout ack_slot",         32'(ack_slot), 0);
    check("timeout door",             32'(door_open), 0);
    tick();
    check("timeout idle t+18",        32'(busy),     0);
    tick(); tick();
    cmd_done = 1'b1; cmd_ok = 1'b1; cmd_slot_rsp = 2'd3;
    tick();
    cmd_done = 1'b0; cmd_ok = 1'b0; cmd_slot_rsp = '0;
    check_quiet("late done");

    // cmd_done in the final allowed cycle beats the timeout.
    do_reset();
    req = 4'b0100;
    tick();
    req = '0;
    repeat (TO - 1) tick();
    check("edge cmd_valid t+16", 32'(cmd_valid), 1);
    cmd_done = 1'b1; cmd_ok = 1'b1; cmd_slot_rsp = 2'd2;
    tick();
    cmd_done = 1'b0; cmd_ok = 1'b0; cmd_slot_rsp = '0;
    check("edge ack_ok",   32'(ack_ok),   1);
    check("edge ack_slot", 32'(ack_slot), 2);
    repeat (DC) tick();
    check_quiet("edge idle");

    // Reset during the ACK cycle abandons the door; rr_ptr returns to 0.
    do_reset();
    req = 4'b0100;
    tick();
    cmd_done = 1'b1; cmd_ok = 1'b1; cmd_slot_rsp = 2'd1;
    tick();
    cmd_done = 1'b0; cmd_ok = 1'b0; cmd_slot_rsp = '0;
    check("rst ack before", 32'(ack), 32'b0100);
    reset = 1'b1; req = 4'b1111;
    tick();
    reset = 1'b0;
    check_quiet("rst mid");
    check("rst mid cmd_exit", 32'(cmd_exit), 0);
    check("rst mid ack_ok",   32'(ack_ok),   0);
    tick();
    check("rst regrant cmd_valid", 32'(cmd_valid), 1);
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0; req = '0;
    check("rst regrant ack", 32'(ack), 32'b0001);
    tick();
    check_quiet("rst idle");

    // Continuous entry requests from all gates with ok = 1 each time.
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid($sformatf("rr%0d", k), nw);
      if (k > 0) check($sformatf("rr%0d gap", k), 32'(nw), DC + 1);
      cmd_done = 1'b1; cmd_ok = 1'b1; cmd_slot_rsp = 2'(k);
      tick();
      cmd_done = 1'b0; cmd_ok = 1'b0; cmd_slot_rsp = '0;
      check($sformatf("rr%0d ack", k), 32'(ack), 32'(rr_exp[k]));
    end
    req = '0;
    repeat (DC) tick();
    check_quiet("rr idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parking_gate_arbiter.md
# parking_gate_arbiter

Shares one slot-allocation core among several parking gates. Each gate raises a level request for an entry or an exit. The block picks one gate, with exits ahead of entries and round-robin within each class. It then issues a single command to the allocation core and waits for its response or a timeout. Finally it acknowledges the gate and drives that gate's door for a fixed time. It sits between the gate sensors and the slot-bookkeeping FSM and is the only master of that FSM's command port.

## Interface
- N_GATES, 4: number of gates (2..8).
- SLOT_W, 2: slot index width (4 slots).
- DOOR_CYCLES, 8: cycles door_open is held after an accepted transaction (>=1).
- TIMEOUT, 16: maximum cycles to wait for cmd_done (>=2).

- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous reset, active-high.
- req  in  N_GATES  per-gate level request; held by the gate until its ack.
- req_exit  in  N_GATES  per-gate type: 1 = exit, 0 = entry.
- req_slot  in  N_GATES*SLOT_W  per-gate exit slot index; gate g uses bits [g*SLOT_W +: SLOT_W]. Ignored for entries.
- cmd_valid  out  1  command to the allocation core; held from issue until done or timeout.
- cmd_exit  out  1  command type, latched at grant.
- cmd_slot  out  SLOT_W  exit slot, latched at grant; 0 for entries.
- cmd_done  in  1  one-cycle response strobe from the core.
- cmd_ok  in  1  valid with cmd_done: 1 = entry assigned or exit freed.
- cmd_slot_rsp  in  SLOT_W  valid with cmd_done: slot assigned or freed.
- ack  out  N_GATES  one-hot, one-cycle completion pulse to the granted gate.
- ack_ok  out  1  valid with ack: 1 = accepted.
- ack_slot  out  SLOT_W  valid with ack; 0 when ack_ok = 0.
- door_open  out  N_GATES  one-hot door drive.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, ACK, DOOR.
- IDLE:
  - If any req bit is set, select a gate, latch its index, type and slot, and go to ISSUE.
  - Selection: if any requesting gate has req_exit = 1, choose among those exit requesters only; otherwise choose among all requesters.
  - Within the chosen class, take the first requester at or after the round-robin pointer rr_ptr, searching upward and wrapping modulo N_GATES.
  - After a grant, rr_ptr = granted index + 1, wrapping to 0 after N_GATES-1.
- ISSUE:
  - cmd_valid = 1 and the timeout counter increments each cycle.
  - cmd_done = 1: latch cmd_ok and cmd_slot_rsp, then go to ACK.
  - Counter reaches TIMEOUT with no cmd_done: latch ok = 0 and slot = 0, then go to ACK.
  - cmd_done arriving in the same cycle as the timeout wins.
- ACK:
  - ack[g] = 1 and ack_ok/ack_slot are driven, for exactly one cycle.
  - If ok = 1, door_open[g] = 1 and the next state is DOOR. Otherwise the next state is IDLE.
- DOOR: door_open[g] stays 1. The door counter runs until door_open has been high DOOR_CYCLES cycles in total, counting the ACK cycle, then the next state is IDLE.
- A gate that drops req after grant does not abort its transaction; ack and door still occur.
- New requests are not sampled outside IDLE.
- cmd_done is ignored outside ISSUE.
- cmd_slot_rsp is passed through unmodified; the arbiter keeps no slot bookkeeping.

## Timing
- Reset values: state IDLE, rr_ptr 0, and every output 0 (cmd_valid, cmd_exit, cmd_slot, ack, ack_ok, ack_slot, door_open, busy).
- Reset asserted mid-transaction:
  - Next cycle everything returns to reset values.
  - The in-flight command is abandoned and no ack is issued.
- req first seen in IDLE at cycle t: cmd_valid and busy = 1 from cycle t+1.
- cmd_done sampled at cycle d: cmd_valid = 0 and ack pulse during cycle d+1.
- Minimum request-to-ack latency is 2 cycles (cmd_done at t+1 gives ack at t+2).
- Timeout: cmd_valid is high for TIMEOUT cycles (t+1 .. t+TIMEOUT); ack with ack_ok = 0 comes at t+TIMEOUT+1.
- Accepted transaction:
  - door_open is high for cycles d+1 .. d+DOOR_CYCLES.
  - IDLE is reached at d+DOOR_CYCLES+1, and the next grant can be sampled in that cycle.
- Rejected transaction: IDLE at d+2.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single entry: req = 0001, req_exit = 0; core answers cmd_done at t+3 with ok = 1, slot = 2 -> cmd_valid t+1..t+3, cmd_exit = 0, ack = 0001 at t+4 with ack_slot = 2, door_open[0] high t+4..t+11, busy low at t+12.
- Exit priority: req = 0011, req_exit = 0010, req_slot[3:2] = 3 -> gate 1 granted first, with cmd_exit = 1 and cmd_slot = 3; gate 0 is granted only after gate 1 returns to IDLE.
- Round robin: all four gates request entries continuously and the core always returns ok = 1 -> grant order 0, 1, 2, 3, 0.
- Rejection (parking full): entry request, cmd_done with ok = 0 -> ack pulse with ack_ok = 0 and ack_slot = 0, door_open never asserted, IDLE two cycles after cmd_done.
- Timeout: cmd_done never arrives -> cmd_valid high for exactly 16 cycles, ack_ok = 0 at t+17; a late cmd_done at t+20 is ignored.
- Reset at the cycle after cmd_done (the ACK cycle) -> no door_open after reset, all outputs 0, rr_ptr = 0, so a simultaneous req = 1111 then grants gate 0.
